// File: rtl/aes_v2_multicycle.sv
// Multi-cycle AES column unit: SubBytes, MixColumns or fused Sub+Mix on one 32-bit column,
// forward or inverse. NSBOX S-boxes process the column in 4/NSBOX chunks.
module aes_v2_multicycle #(
  parameter int NSBOX    = 4,
  parameter bit FUSED_EN = 1'b1
) (
  input  logic        g_clk,
  input  logic        g_resetn,
  input  logic        valid,
  input  logic        dec,
  input  logic [1:0]  op,
  input  logic [31:0] rs1,
  output logic        ready,
  output logic [31:0] rd
);

  localparam int NCHUNK = (NSBOX > 0) ? (4 / NSBOX) : 1;
  localparam int CW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [CW-1:0] LAST = CW'(NCHUNK - 1);

  if (NSBOX != 1 && NSBOX != 2 && NSBOX != 4) begin : g_bad_nsbox
    $error("aes_v2_multicycle: NSBOX must be 1, 2 or 4");
  end

  typedef enum logic [1:0] {IDLE, SUB, MIX, DONE} state_e;

  state_e        state_q;
  logic [CW-1:0] cnt_q;
  logic          dec_q;
  logic [1:0]    op_q;
  logic [31:0]   result_q;
  logic          ready_q;

  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] acc;
    logic [7:0] p;
    acc = 8'h00;
    p   = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) acc = acc ^ p;
      p = xt(p);
    end
    return acc;
  endfunction

  // Multiplicative inverse as a^254 (square-and-multiply); maps 0 to 0 as AES requires.
  function automatic logic [7:0] ginv(input logic [7:0] a);
    logic [7:0] r;
    logic [7:0] p;
    r = 8'h01;
    p = a;
    for (int i = 0; i < 7; i++) begin
      p = gmul(p, p);
      r = gmul(r, p);
    end
    return r;
  endfunction

  function automatic logic [7:0] rl(input logic [7:0] a, input int n);
    return (a << n) | (a >> (8 - n));
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] a, input logic d);
    logic [7:0] t;
    if (!d) begin
      t = ginv(a);
      return t ^ rl(t, 1) ^ rl(t, 2) ^ rl(t, 3) ^ rl(t, 4) ^ 8'h63;
    end
    t = rl(a, 1) ^ rl(a, 3) ^ rl(a, 6) ^ 8'h05;
    return ginv(t);
  endfunction

  function automatic logic [31:0] gmul4(input logic [31:0] c, input logic [7:0] k);
    logic [31:0] r;
    for (int i = 0; i < 4; i++) r[8*i +: 8] = gmul(c[8*i +: 8], k);
    return r;
  endfunction

  // Byte i of each rotated copy is byte i+1, i+2, i+3 of the column (row 0 = bits 7:0).
  function automatic logic [31:0] mixcol(input logic [31:0] c, input logic d);
    logic [7:0] k0, k1, k2, k3;
    k0 = d ? 8'h0e : 8'h02;
    k1 = d ? 8'h0b : 8'h03;
    k2 = d ? 8'h0d : 8'h01;
    k3 = d ? 8'h09 : 8'h01;
    return gmul4(c, k0) ^ gmul4({c[7:0], c[31:8]}, k1) ^
           gmul4({c[15:0], c[31:16]}, k2) ^ gmul4({c[23:0], c[31:24]}, k3);
  endfunction

  logic [4:0]  sb_base [NSBOX];
  logic [7:0]  sb_in   [NSBOX];
  logic [7:0]  sb_out  [NSBOX];
  logic [31:0] sub_res;

  for (genvar gi = 0; gi < NSBOX; gi++) begin : g_sbox
    assign sb_base[gi] = 5'(8 * (NSBOX * int'(cnt_q) + gi));
    assign sb_in[gi]   = result_q[sb_base[gi] +: 8];
    assign sb_out[gi]  = sbox(sb_in[gi], dec_q);
  end

  always_comb begin
    sub_res = result_q;
    for (int k = 0; k < NSBOX; k++) sub_res[sb_base[k] +: 8] = sb_out[k];
  end

  always_ff @(posedge g_clk) begin
    if (!g_resetn) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      dec_q    <= 1'b0;
      op_q     <= 2'b00;
      result_q <= 32'h0;
      ready_q  <= 1'b0;
    end else begin
      ready_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (valid) begin
            result_q <= rs1;
            dec_q    <= dec;
            op_q     <= op;
            cnt_q    <= '0;
            if (op == 2'b00 || (op == 2'b10 && FUSED_EN)) begin
              state_q <= SUB;
            end else if (op == 2'b01) begin
              state_q <= MIX;
            end else begin
              state_q  <= DONE;
              result_q <= 32'h0;
              ready_q  <= 1'b1;
            end
          end
        end
        SUB: begin
          if (!valid) begin
            state_q <= IDLE;
          end else begin
            result_q <= sub_res;
            cnt_q    <= cnt_q + 1'b1;
            if (cnt_q == LAST) begin
              if (op_q == 2'b10) begin
                state_q <= MIX;
              end else begin
                state_q <= DONE;
                ready_q <= 1'b1;
              end
            end
          end
        end
        MIX: begin
          if (!valid) begin
            state_q <= IDLE;
          end else begin
            result_q <= mixcol(result_q, dec_q);
            state_q  <= DONE;
            ready_q  <= 1'b1;
          end
        end
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign ready = ready_q;
  assign rd    = result_q;

endmodule

// File: tb/tb_aes_v2_multicycle.sv
// Scoreboard bench for aes_v2_multicycle: four configurations (NSBOX 4/2/1 fused, NSBOX 2 unfused),
// directed vectors, abort, mid-op reset and randomised back-to-back traffic.
module tb_aes_v2_multicycle;

  logic        clk = 1'b0;
  logic        rstn;
  logic        valid_s [4];
  logic        dec_s   [4];
  logic [1:0]  op_s    [4];
  logic [31:0] rs1_s   [4];
  logic        ready_s [4];
  logic [31:0] rd_s    [4];

  always #5 clk = ~clk;

  for (genvar gi = 0; gi < 4; gi++) begin : g_dut
    aes_v2_multicycle #(
      .NSBOX   ((gi == 0) ? 4 : (gi == 2) ? 1 : 2),
      .FUSED_EN(gi != 3)
    ) u_dut (
      .g_clk   (clk),
      .g_resetn(rstn),
      .valid   (valid_s[gi]),
      .dec     (dec_s[gi]),
      .op      (op_s[gi]),
      .rs1     (rs1_s[gi]),
      .ready   (ready_s[gi]),
      .rd      (rd_s[gi])
    );
  end

  typedef struct {
    int          u;
    logic [31:0] rd;
    int          lat;
  } exp_t;

  exp_t       sb_q [$];
  int         total = 0;
  int         bad   = 0;
  logic [7:0] sbox_t  [256];
  logic [7:0] isbox_t [256];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic int nsb_of(input int u);
    return (u == 0) ? 4 : (u == 2) ? 1 : 2;
  endfunction

  function automatic logic [7:0] rl8(input logic [7:0] a, input int n);
    return (a << n) | (a >> (8 - n));
  endfunction

  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  // S-box from the 3/(1/3) generator walk; inverse by table inversion.
  task automatic build_tables();
    logic [7:0] p, q, x;
    p = 8'h01;
    q = 8'h01;
    do begin
      p = p ^ {p[6:0], 1'b0} ^ (p[7] ? 8'h1b : 8'h00);
      q = q ^ {q[6:0], 1'b0};
      q = q ^ {q[5:0], 2'b00};
      q = q ^ {q[3:0], 4'h0};
      if (q[7]) q = q ^ 8'h09;
      x = q ^ rl8(q, 1) ^ rl8(q, 2) ^ rl8(q, 3) ^ rl8(q, 4);
      sbox_t[p] = x ^ 8'h63;
    end while (p != 8'h01);
    sbox_t[0] = 8'h63;
    for (int i = 0; i < 256; i++) isbox_t[sbox_t[i]] = 8'(i);
  endtask

  function automatic logic [31:0] sub_m(input logic [31:0] x, input logic d);
    logic [31:0] r;
    for (int i = 0; i < 4; i++) r[8*i +: 8] = d ? isbox_t[x[8*i +: 8]] : sbox_t[x[8*i +: 8]];
    return r;
  endfunction

  function automatic logic [31:0] mix_f(input logic [31:0] x);
    logic [7:0] a0, a1, a2, a3, r0, r1, r2, r3;
    {a3, a2, a1, a0} = x;
    r0 = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
    r1 = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
    r2 = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
    r3 = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
    return {r3, r2, r1, r0};
  endfunction

  // The MixColumns matrix has order 4, so its inverse is its cube.
  function automatic logic [31:0] mix_m(input logic [31:0] x, input logic d);
    return d ? mix_f(mix_f(mix_f(x))) : mix_f(x);
  endfunction

  task automatic model(input int u, input logic [1:0] op, input logic d, input logic [31:0] x,
                       output logic [31:0] r, output int lat);
    int nch;
    nch = 4 / nsb_of(u);
    case (op)
      2'b00: begin r = sub_m(x, d); lat = nch + 1; end
      2'b01: begin r = mix_m(x, d); lat = 2; end
      2'b10: begin
        if (u != 3) begin r = mix_m(sub_m(x, d), d); lat = nch + 2; end
        else begin r = 32'h0; lat = 1; end
      end
      default: begin r = 32'h0; lat = 1; end
    endcase
  endtask

  // Drop valid after a completed op and let the unit return to IDLE.
  task automatic idle(input int u);
    valid_s[u] = 1'b0;
    @(posedge clk); #1;
    chk("pulse width", {31'b0, ready_s[u]}, 32'h0);
    @(posedge clk); #1;
  endtask

  // b2b: called in the DONE cycle of the previous op with valid still high.
  task automatic issue(input int u, input logic [1:0] op, input logic d, input logic [31:0] x,
                       input bit b2b, input string tag);
    exp_t        e;
    logic [31:0] er;
    int          el;
    int          cyc;
    model(u, op, d, x, er, el);
    e.u   = u;
    e.rd  = er;
    e.lat = b2b ? el + 1 : el;
    sb_q.push_back(e);
    valid_s[u] = 1'b1;
    op_s[u]    = op;
    dec_s[u]   = d;
    rs1_s[u]   = x;
    cyc = 0;
    while (cyc < 30) begin
      @(posedge clk); #1;
      cyc++;
      if (cyc == (b2b ? 2 : 1)) begin
        rs1_s[u] = $urandom;
        dec_s[u] = 1'($urandom_range(0, 1));
        op_s[u]  = 2'($urandom_range(0, 3));
      end
      if (ready_s[u]) break;
    end
    e = sb_q.pop_front();
    chk({tag, " lat"}, 32'(cyc), 32'(e.lat));
    chk({tag, " rd"}, rd_s[e.u], e.rd);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic any;
    build_tables();
    rstn = 1'b0;
    for (int u = 0; u < 4; u++) begin
      valid_s[u] = 1'b0;
      dec_s[u]   = 1'b0;
      op_s[u]    = 2'b00;
      rs1_s[u]   = 32'h0;
    end
    repeat (3) @(posedge clk);
    #1;
    for (int u = 0; u < 4; u++) begin
      chk("reset ready", {31'b0, ready_s[u]}, 32'h0);
      chk("reset rd", rd_s[u], 32'h0);
    end
    rstn = 1'b1;
    @(posedge clk); #1;

    issue(0, 2'b00, 1'b0, 32'h00000000, 1'b0, "t1 sub n4");
    chk("t1 const", rd_s[0], 32'h63636363);
    issue(0, 2'b01, 1'b0, 32'h455313DB, 1'b1, "t3 mix");
    chk("t3 const", rd_s[0], 32'hBCA14D8E);
    issue(0, 2'b01, 1'b1, 32'hBCA14D8E, 1'b1, "t3 invmix");
    chk("t3 inv const", rd_s[0], 32'h455313DB);
    idle(0);

    issue(2, 2'b00, 1'b0, 32'h10015300, 1'b0, "t2 sub n1");
    chk("t2 const", rd_s[2], 32'hCA7CED63);
    issue(2, 2'b00, 1'b1, 32'hCA7CED63, 1'b1, "t2 invsub n1");
    chk("t2 inv const", rd_s[2], 32'h10015300);
    idle(2);

    issue(1, 2'b10, 1'b0, 32'h00000000, 1'b0, "t4 fused");
    chk("t4 const", rd_s[1], 32'h63636363);
    idle(1);
    issue(3, 2'b10, 1'b0, 32'h00000000, 1'b0, "t4 nofuse");
    chk("t4 nofuse const", rd_s[3], 32'h0);
    idle(3);

    // Abort after the first chunk: no pulse, partial result stays visible.
    valid_s[2] = 1'b1;
    op_s[2]    = 2'b00;
    dec_s[2]   = 1'b0;
    rs1_s[2]   = 32'h3C5A96F1;
    repeat (2) begin @(posedge clk); #1; end
    valid_s[2] = 1'b0;
    any = 1'b0;
    repeat (6) begin
      @(posedge clk); #1;
      if (ready_s[2]) any = 1'b1;
    end
    chk("abort ready", {31'b0, any}, 32'h0);
    chk("abort rd", rd_s[2], {24'h3C5A96, sbox_t[8'hF1]});
    issue(2, 2'b01, 1'b0, 32'h01020304, 1'b0, "after abort");
    idle(2);

    // Reset in the middle of a SubBytes sequence.
    valid_s[2] = 1'b1;
    op_s[2]    = 2'b00;
    rs1_s[2]   = 32'h12345678;
    repeat (2) begin @(posedge clk); #1; end
    rstn       = 1'b0;
    valid_s[2] = 1'b0;
    @(posedge clk); #1;
    chk("midrst ready", {31'b0, ready_s[2]}, 32'h0);
    chk("midrst rd", rd_s[2], 32'h0);
    rstn = 1'b1;
    @(posedge clk); #1;
    issue(2, 2'b10, 1'b1, 32'hDEADBEEF, 1'b0, "after reset");
    idle(2);

    for (int u = 0; u < 4; u++) begin
      for (int n = 0; n < 300; n++) begin
        bit b2b;
        b2b = (n > 0) && ($urandom_range(0, 1) == 1);
        if (!b2b && n > 0) idle(u);
        issue(u, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), $urandom, b2b, "rand");
      end
      idle(u);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
